// File: rtl/fifo_wr_arb_if.sv
// Write-port bundle between the requesters, the round-robin arbiter and the async FIFO write side.
// master: the arbiter; slave: the requester/FIFO environment.
interface fifo_wr_arb_if #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8
) ();
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*DSIZE-1:0] wdata_in;
    logic                  fifo_wfull;
    logic [NREQ-1:0]       gnt;
    logic                  fifo_winc;
    logic [DSIZE-1:0]      fifo_wdata;
    logic [OW-1:0]         owner;
    logic                  busy;

    modport master (
        input  req, wdata_in, fifo_wfull,
        output gnt, fifo_winc, fifo_wdata, owner, busy
    );

    modport slave (
        output req, wdata_in, fifo_wfull,
        input  gnt, fifo_winc, fifo_wdata, owner, busy
    );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters,
// holding each grant for up to BURST beats and stalling while the FIFO is full.
module fifo_wr_arb #(
    parameter int NREQ  = 4,
    parameter int DSIZE = 8,
    parameter int BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    fifo_wr_arb_if.master bus
);
    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;

    logic            sel_found_s;
    logic [OW-1:0]   sel_idx_s;
    logic [OW-1:0]   next_ptr_s;
    logic [NREQ-1:0] gnt_s;
    logic            winc_s;
    logic [DSIZE-1:0] wdata_s;
    logic            busy_s;

    // Circular first-set search starting at rr_ptr; explicit wrap keeps non-power-of-two NREQ correct.
    always_comb begin
        int            idx;
        logic [OW-1:0] idx_v;
        sel_found_s = 1'b0;
        sel_idx_s   = '0;
        idx         = 0;
        idx_v       = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            idx_v = OW'(idx);
            if (!sel_found_s && bus.req[idx_v]) begin
                sel_found_s = 1'b1;
                sel_idx_s   = idx_v;
            end else begin
                sel_found_s = sel_found_s;
            end
        end
    end

    // Pointer to the requester after the current owner.
    always_comb begin
        if (owner_q == OW'(NREQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = owner_q + OW'(1);
        end
    end

    // Next-state and port outputs; outputs depend only on registered state and live inputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        gnt_s      = '0;
        winc_s     = 1'b0;
        wdata_s    = '0;
        busy_s     = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_found_s) begin
                    owner_d    = sel_idx_s;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end else begin
                    state_d    = IDLE;
                end
            end
            GRANT: begin
                busy_s  = 1'b1;
                gnt_s   = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
                wdata_s = bus.wdata_in[owner_q*DSIZE +: DSIZE];
                winc_s  = bus.req[owner_q] & ~bus.fifo_wfull;
                if (!bus.req[owner_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr_s;
                end else if (winc_s) begin
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == CW'(BURST - 1)) begin
                        state_d  = IDLE;
                        rr_ptr_d = next_ptr_s;
                    end else begin
                        state_d  = GRANT;
                    end
                end else begin
                    // FIFO full: hold grant indefinitely without counting a beat.
                    state_d = GRANT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.gnt        = gnt_s;
    assign bus.fifo_winc  = winc_s;
    assign bus.fifo_wdata = wdata_s;
    assign bus.busy       = busy_s;
    assign bus.owner      = owner_q;
endmodule
